// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared LSU funct3 codes, state enum and request legality check
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

  // True when a request must be refused without touching the bus.
  function automatic logic lsu_bad_req(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    if (we && f3[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/wb_lsu_lane.sv
// rtl/wb_lsu_lane.sv - byte-lane select, store replication and load extract/extend
module wb_lsu_lane
  import core_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_byte_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    shifted = i_rdata >> {i_byte_off, 3'b000};
    sext    = ~i_funct3[2];
    o_sel   = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = shifted;
    case (i_funct3[1:0])
      2'b00: begin
        o_sel   = 4'b0001 << i_byte_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{shifted[7] & sext}}, shifted[7:0]};
      end
      2'b01: begin
        o_sel   = i_byte_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{shifted[15] & sext}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// rtl/wb_lsu_master.sv - single-beat pipelined Wishbone master for the load/store unit
module wb_lsu_master
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_we,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_valid,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic            o_resp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [XLEN-3:0] o_wb_addr,
  output logic [XLEN-1:0] o_wb_data,
  output logic [3:0]      o_wb_sel,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            wb_we_q, wb_we_d;
  logic [XLEN-3:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [3:0]      sel_q, sel_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [2:0]      lane_f3;
  logic [1:0]      lane_off;
  logic [3:0]      lane_sel;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_rdata;

  // Store lanes come from the live request at accept; load extract uses the latched request.
  assign lane_f3  = (state_q == LSU_IDLE) ? i_req_funct3    : f3_q;
  assign lane_off = (state_q == LSU_IDLE) ? i_req_addr[1:0] : off_q;

  wb_lsu_lane u_lane (
    .i_funct3   (lane_f3),
    .i_byte_off (lane_off),
    .i_wdata    (i_req_wdata),
    .i_rdata    (i_wb_data),
    .o_sel      (lane_sel),
    .o_wdata    (lane_wdata),
    .o_rdata    (lane_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= LSU_IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      cnt_q     <= 8'd0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      sel_q     <= 4'b0000;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    wb_we_d   = wb_we_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          f3_d    = i_req_funct3;
          off_d   = i_req_addr[1:0];
          rdata_d = '0;
          if (lsu_bad_req(i_req_we, i_req_funct3, i_req_addr[1:0])) begin
            state_d = LSU_RESP;
            err_d   = 1'b1;
          end else begin
            state_d   = LSU_REQ;
            err_d     = 1'b0;
            cnt_d     = 8'd0;
            cyc_d     = 1'b1;
            stb_d     = 1'b1;
            wb_we_d   = i_req_we;
            wb_addr_d = i_req_addr[XLEN-1:2];
            wb_data_d = i_req_we ? lane_wdata : '0;
            sel_d     = lane_sel;
          end
        end
      end
      LSU_REQ, LSU_WAIT: begin
        if (i_wb_ack || i_wb_err) begin
          state_d = LSU_RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = i_wb_err;
          rdata_d = (i_wb_err || we_q) ? '0 : lane_rdata;
        end else if (cnt_q == TO_LAST) begin
          state_d = LSU_RESP;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (state_q == LSU_REQ && !i_wb_stall) begin
            state_d = LSU_WAIT;
            stb_d   = 1'b0;
          end
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  assign o_req_ready  = (state_q == LSU_IDLE);
  assign o_resp_valid = (state_q == LSU_RESP);
  assign o_resp_rdata = rdata_q;
  assign o_resp_err   = err_q;
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_we      = wb_we_q;
  assign o_wb_addr    = wb_addr_q;
  assign o_wb_data    = wb_data_q;
  assign o_wb_sel     = sel_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb/tb_wb_lsu_master.sv - directed and randomized checks of wb_lsu_master against a behavioural model
module tb_wb_lsu_master;

  localparam int XLEN = 32;
  localparam int TO   = 20;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_we;
  logic [2:0]      i_req_funct3;
  logic [XLEN-1:0] i_req_addr;
  logic [XLEN-1:0] i_req_wdata;
  logic            o_resp_valid;
  logic [XLEN-1:0] o_resp_rdata;
  logic            o_resp_err;
  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic            o_wb_we;
  logic [XLEN-3:0] o_wb_addr;
  logic [XLEN-1:0] o_wb_data;
  logic [3:0]      o_wb_sel;
  logic [XLEN-1:0] i_wb_data;
  logic            i_wb_stall;
  logic            i_wb_ack;
  logic            i_wb_err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  wb_lsu_master #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_resp_valid (o_resp_valid),
    .o_resp_rdata (o_resp_rdata),
    .o_resp_err   (o_resp_err),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .o_wb_sel     (o_wb_sel),
    .i_wb_data    (i_wb_data),
    .i_wb_stall   (i_wb_stall),
    .i_wb_ack     (i_wb_ack),
    .i_wb_err     (i_wb_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
    return ((32'd1 << m_size(f3)) - 32'd1) << (a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * (a % 4));
    if (m_size(f3) == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (m_size(f3) == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit stall);
    @(negedge i_clk);
    chk("req_ready", o_req_ready, 1);
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = a;
    i_req_wdata  = wd;
    i_wb_stall   = stall;
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int stalls,
                        input int dly, input logic berr, input logic back);
    logic [31:0] exp_rd;
    issue(we, f3, a, wd, stalls > 0);
    if (m_bad(we, f3, a)) begin
      chk("bad_resp_valid", o_resp_valid, 1);
      chk("bad_resp_err", o_resp_err, 1);
      chk("bad_resp_rdata", o_resp_rdata, 0);
      chk("bad_no_cyc", o_wb_cyc, 0);
      @(negedge i_clk);
      chk("bad_resp_pulse", o_resp_valid, 0);
      chk("bad_no_cyc2", o_wb_cyc, 0);
      return;
    end
    chk("cyc", o_wb_cyc, 1);
    chk("stb", o_wb_stb, 1);
    chk("we", o_wb_we, we);
    chk("addr", {2'b00, o_wb_addr}, a >> 2);
    chk("sel", o_wb_sel, m_sel(f3, a));
    if (we) chk("wdata", o_wb_data, m_wdata(f3, wd));
    for (int i = 0; i < stalls; i++) begin
      @(negedge i_clk);
      chk("stall_stb", o_wb_stb, 1);
      chk("stall_addr", {2'b00, o_wb_addr}, a >> 2);
      chk("stall_sel", o_wb_sel, m_sel(f3, a));
    end
    i_wb_stall = 1'b0;
    @(negedge i_clk);
    chk("wait_stb", o_wb_stb, 0);
    chk("wait_cyc", o_wb_cyc, 1);
    chk("early_resp", o_resp_valid, 0);
    repeat (dly) @(negedge i_clk);
    i_wb_ack  = back | ~berr;
    i_wb_err  = berr;
    i_wb_data = rd;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    exp_rd = (berr || we) ? 32'd0 : m_rdata(f3, a, rd);
    chk("resp_valid", o_resp_valid, 1);
    chk("resp_err", o_resp_err, berr);
    chk("resp_rdata", o_resp_rdata, exp_rd);
    chk("resp_cyc", o_wb_cyc, 0);
    @(negedge i_clk);
    chk("resp_pulse", o_resp_valid, 0);
    chk("ready_after", o_req_ready, 1);
  endtask

  initial begin
    int n;
    logic [2:0] f3s [8];
    logic [2:0] f3;
    logic we;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    i_req_we = 1'b0;
    i_req_funct3 = 3'd0;
    i_req_addr = '0;
    i_req_wdata = '0;
    i_wb_data = '0;
    i_wb_stall = 1'b0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", o_req_ready, 1);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_we", o_wb_we, 0);
    chk("rst_sel", o_wb_sel, 0);
    chk("rst_addr", {2'b00, o_wb_addr}, 0);
    chk("rst_data", o_wb_data, 0);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_rdata", o_resp_rdata, 0);
    chk("rst_resp_err", o_resp_err, 0);
    i_reset = 1'b0;

    do_req(1'b0, 3'd2, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
    chk("lw_const_rdata", o_resp_rdata, 32'hDEAD_BEEF);
    do_req(1'b0, 3'd0, 32'h0000_0013, 32'd0, 32'h8011_2233, 0, 0, 1'b0, 1'b0);
    chk("lb_const_rdata", o_resp_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h0000_0013, 32'd0, 32'h8011_2233, 0, 1, 1'b0, 1'b0);
    chk("lbu_const_rdata", o_resp_rdata, 32'h0000_0080);
    do_req(1'b0, 3'd5, 32'h0000_0012, 32'd0, 32'h8011_2233, 0, 0, 1'b0, 1'b0);
    chk("lhu_const_rdata", o_resp_rdata, 32'h0000_8011);
    do_req(1'b1, 3'd1, 32'h0000_0006, 32'h0000_ABCD, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
    do_req(1'b0, 3'd2, 32'h0000_0002, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0);
    do_req(1'b0, 3'd1, 32'h0000_0001, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0);
    do_req(1'b0, 3'd2, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 3, 0, 1'b0, 1'b0);
    do_req(1'b0, 3'd2, 32'h0000_0104, 32'd0, 32'h1111_2222, 0, 0, 1'b1, 1'b1);

    issue(1'b0, 3'd2, 32'h0000_0020, 32'd0, 1'b0);
    n = 0;
    while (o_wb_cyc === 1'b1 && n < TO + 10) begin
      n++;
      @(negedge i_clk);
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_resp_valid", o_resp_valid, 1);
    chk("timeout_resp_err", o_resp_err, 1);
    chk("timeout_stb", o_wb_stb, 0);
    @(negedge i_clk);

    issue(1'b0, 3'd2, 32'h0000_0030, 32'd0, 1'b0);
    @(negedge i_clk);
    chk("pre_rst_cyc", o_wb_cyc, 1);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("midrst_cyc", o_wb_cyc, 0);
    chk("midrst_stb", o_wb_stb, 0);
    chk("midrst_resp", o_resp_valid, 0);
    chk("midrst_ready", o_req_ready, 1);
    i_wb_ack = 1'b1;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    chk("late_ack_resp", o_resp_valid, 0);
    @(negedge i_clk);
    chk("late_ack_resp2", o_resp_valid, 0);
    chk("late_ack_cyc", o_wb_cyc, 0);

    i_wb_ack = 1'b1;
    i_wb_err = 1'b1;
    @(negedge i_clk);
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    chk("stray_resp", o_resp_valid, 0);
    chk("stray_ready", o_req_ready, 1);

    for (int k = 0; k < 40; k++) begin
      f3 = f3s[$urandom_range(0, 7)];
      we = 1'($urandom_range(0, 1));
      do_req(we, f3, $urandom, $urandom, $urandom, $urandom_range(0, 2),
             $urandom_range(0, 2), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
